// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// Shows a per-frame snapshot of a 16-bit value as hex, with blanking, enables and decimal points.
module seg7_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] val,
  input  logic [3:0]  digit_en,
  input  logic [3:0]  dp_mask,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [3:0]    r_an;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic          r_frame_done;

  logic          w_tick;
  logic [3:0]    w_nib;
  logic          w_lz_blank;
  logic          w_dark;
  logic [6:0]    w_pat;

  function automatic logic [6:0] seg_pattern(input logic [3:0] nib);
    logic [6:0] p;
    case (nib)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      default: p = 7'h71;
    endcase
    return p;
  endfunction

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));
  assign w_nib  = r_shadow[{r_idx, 2'b00} +: 4];
  assign w_pat  = seg_pattern(w_nib);

  // A digit is a leading zero when it and every more-significant nibble are zero; digit 0 always shows.
  always_comb begin
    w_lz_blank = 1'b0;
    case (r_idx)
      2'd1:    w_lz_blank = (r_shadow[15:4]  == 12'h000);
      2'd2:    w_lz_blank = (r_shadow[15:8]  == 8'h00);
      2'd3:    w_lz_blank = (r_shadow[15:12] == 4'h0);
      default: w_lz_blank = 1'b0;
    endcase
  end

  assign w_dark = (r_presc < PW'(BLANK_CYC)) || !digit_en[r_idx] || (lz_en && w_lz_blank);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc      <= '0;
      r_idx        <= 2'd0;
      r_shadow     <= 16'h0000;
      r_an         <= 4'hF;
      r_seg        <= 7'h7F;
      r_dp         <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_shadow     <= val;
          r_frame_done <= 1'b1;
        end
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      // Output register reflects the slot state before this edge's update.
      if (w_dark) begin
        r_an  <= 4'hF;
        r_seg <= 7'h7F;
        r_dp  <= 1'b1;
      end else begin
        r_an  <= ~(4'b0001 << r_idx);
        r_seg <= ~w_pat;
        r_dp  <= ~dp_mask[r_idx];
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign dp         = r_dp;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver with SCAN_DIV=4, BLANK_CYC=1.
// Stimulus pushes hand-derived per-cycle expectations; a negedge monitor pops and compares.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] val;
  logic [3:0]  digit_en;
  logic [3:0]  dp_mask;
  logic        lz_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;

  seg7_scan_driver #(.SCAN_DIV(4), .BLANK_CYC(1)) dut (
    .clk(clk), .rst_n(rst_n), .val(val), .digit_en(digit_en), .dp_mask(dp_mask),
    .lz_en(lz_en), .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      n_vec++;
      if ({an, seg, dp, frame_done} !== e) begin
        n_err++;
        $display("FAIL out[%0d]: got an=%b seg=%h dp=%b fd=%b, want an=%b seg=%h dp=%b fd=%b",
                 n_out, an, seg, dp, frame_done, e.an, e.seg, e.dp, e.fd);
      end
      n_vec++;
      if ($countones(~an) > 1) begin
        n_err++;
        $display("FAIL one_anode[%0d]: got an=%b, want at most one low bit", n_out, an);
      end
      n_out++;
    end
  end

  task automatic push(input logic [3:0] a, input logic [6:0] s, input logic d, input logic f);
    exp_t e;
    e.an  = a;
    e.seg = s;
    e.dp  = d;
    e.fd  = f;
    q.push_back(e);
  endtask

  task automatic step_reset();
    @(posedge clk);
    #1;
    push(4'hF, 7'h7F, 1'b1, 1'b0);
  endtask

  // segs packs slot3..slot0 (slot0 in bits 6:0); lit/dpon are per-slot masks.
  task automatic frame(input int ncyc, input logic [27:0] segs, input logic [3:0] lit,
                       input logic [3:0] dpon, input logic [15:0] nv, input bit chg);
    for (int j = 0; j < ncyc; j++) begin
      int s;
      s = j / 4;
      @(posedge clk);
      #1;
      if ((j % 4) == 0 || !lit[s])
        push(4'hF, 7'h7F, 1'b1, j == 15);
      else
        push(4'(~(4'b0001 << s)), segs[s*7 +: 7], ~dpon[s], j == 15);
      if (chg && j == 5) val = nv;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    val      = 16'h1234;
    digit_en = 4'hF;
    dp_mask  = 4'h0;
    lz_en    = 1'b0;
    repeat (3) step_reset();
    rst_n = 1'b1;

    frame(16, {4{7'h40}}, 4'hF, 4'h0, 16'h0000, 1'b0);
    frame(16, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF, 4'h0, 16'h00A0, 1'b1);
    lz_en = 1'b1;
    frame(16, {7'h7F, 7'h7F, 7'h08, 7'h40}, 4'b0011, 4'h0, 16'h0000, 1'b1);
    frame(16, {4{7'h40}}, 4'b0001, 4'h0, 16'h1111, 1'b1);
    lz_en = 1'b0;
    frame(16, {4{7'h79}}, 4'hF, 4'h0, 16'h2222, 1'b1);
    frame(16, {4{7'h24}}, 4'hF, 4'h0, 16'h0000, 1'b0);
    digit_en = 4'b0111;
    dp_mask  = 4'b0100;
    frame(16, {4{7'h24}}, 4'b0111, 4'b0100, 16'h0000, 1'b0);
    frame(10, {4{7'h24}}, 4'b0111, 4'b0100, 16'h0000, 1'b0);
    rst_n = 1'b0;
    step_reset();
    rst_n = 1'b1;
    frame(16, {4{7'h40}}, 4'b0111, 4'b0100, 16'h0000, 1'b0);
    digit_en = 4'hF;
    dp_mask  = 4'h0;
    frame(16, {4{7'h24}}, 4'hF, 4'h0, 16'h0000, 1'b0);

    @(negedge clk);
    #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a 4-digit common-anode 7-segment display.
- Consumes the 16-bit count produced by the up/down counter stage and shows it as 4 hex digits.
- Snapshots the value once per frame, so digits never tear mid-scan.
- Supports leading-zero blanking, per-digit enable, per-digit decimal point and anti-ghost blanking.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz); legal range ≥2.
- BLANK_CYC, 2: cycles at the start of each slot during which all anodes are off; must be < SCAN_DIV.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- val  in  16  value to display; digit k shows val[4k+3:4k].
- digit_en  in  4  per-digit enable; 0 = digit k always dark.
- dp_mask  in  4  1 = decimal point lit on digit k.
- lz_en  in  1  1 = blank leading zero digits.
- an  out  4  anode selects, active-low, registered.
- seg  out  7  segments, active-low, registered; seg[0]=a … seg[6]=g.
- dp  out  1  decimal point, active-low, registered.
- frame_done  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n). Reset is sampled only on the rising edge of clk.
- Reset values: an=4'b1111, seg=7'h7F, dp=1, frame_done=0. Internally: prescaler=0, slot index idx=0, snapshot shadow=16'h0000.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - On the cycle where it equals SCAN_DIV-1 (tick): prescaler wraps to 0 and idx advances 0→1→2→3→0.
- Snapshot:
  - On a tick while idx==3: shadow<=val and frame_done<=1 for exactly one cycle; otherwise frame_done<=0.
  - One frame = 4*SCAN_DIV cycles.
  - The first frame after reset displays shadow=0.
- Output register: every cycle an/seg/dp are loaded from the current idx, shadow and prescaler. Outputs therefore lag idx/prescaler by one cycle.
- Digit k=idx is dark (an all 1, seg=7'h7F, dp=1) if any of the following holds:
  - prescaler < BLANK_CYC;
  - digit_en[k]==0;
  - lz_en==1, k≠0, and shadow nibbles k..3 are all zero.
- Digit 0 is never blanked by lz_en.
- Otherwise: an = ~(4'b0001<<k), seg = ~pattern(nibble), dp = ~dp_mask[k].
- Segment patterns (active-high gfedcba):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
- Changes to val mid-frame have no visible effect until the next snapshot.
- digit_en, dp_mask and lz_en are not snapshotted; they take effect on the next output update.
- Reset mid-frame: the next edge forces all reset values; the scan restarts at slot 0 with shadow=0.
- At most one anode is low in any cycle.

Test Plan:
- Reset (SCAN_DIV=4, BLANK_CYC=1 for all cases):
  - Stimulus: rst_n=0 for 3 cycles with val=16'h1234.
  - Required: an=4'hF, seg=7'h7F, dp=1, frame_done=0 throughout.
- Normal scan:
  - Stimulus: release reset, val=16'h1234, digit_en=4'hF, dp_mask=0, lz_en=0.
  - First frame: each slot shows seg=7'h40 ("0").
  - frame_done pulses every 16 cycles.
  - Next frame: slot0 an=1110 seg=7'h19; slot1 an=1101 seg=7'h30; slot2 an=1011 seg=7'h24; slot3 an=0111 seg=7'h79.
  - The first output cycle of each slot is dark.
- Leading zeros:
  - Stimulus: lz_en=1, val=16'h00A0.
  - Required: slots 3 and 2 dark; slot1 seg=7'h08; slot0 seg=7'h40.
  - With val=16'h0000: only slot0 lit, seg=7'h40.
- Snapshot/tearing:
  - Stimulus: change val 16'h1111→16'h2222 during slot 1.
  - Required: slots 1–3 still show seg=7'h79 ("1"); "2" (7'h24) appears only after the next frame_done.
- Enables and decimal point:
  - Stimulus: digit_en=4'b0111, dp_mask=4'b0100.
  - Required: an[3] never 0; dp=0 only during slot 2's lit cycles; dp=1 elsewhere.
- Reset mid-frame:
  - Stimulus: assert rst_n=0 for 1 cycle during slot 2.
  - Required: the next edge gives an=F, seg=7F, dp=1; after release, scanning resumes at slot 0 showing "0", and frame_done first pulses 16 cycles later.
